// File: rtl/sample_frame_packer.sv
// Captures one valid/last-delimited sample burst into a local buffer, then replays it
// as a framed byte stream: two header bytes, 16-bit length, payload and an 8-bit checksum.
module sample_frame_packer #(
  parameter int unsigned P_ADDR_W  = 10,
  parameter int unsigned P_MAX_LEN = 1024,
  parameter logic [7:0]  P_HDR0    = 8'h55,
  parameter logic [7:0]  P_HDR1    = 8'hAA
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_sam_data,
  input  logic       i_sam_data_vld,
  input  logic       i_sam_data_last,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_drop,
  output logic       o_trunc
);

  localparam int unsigned DEPTH      = 1 << P_ADDR_W;
  localparam logic [15:0] MAX_LEN_M1 = 16'(P_MAX_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SKIP,
    ST_SEND
  } cap_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_H0,
    TX_H1,
    TX_LH,
    TX_LL,
    TX_PAY,
    TX_CK,
    TX_LAST
  } tx_state_t;

  logic [7:0]          mem [DEPTH];
  logic [7:0]          mem_q;
  logic [P_ADDR_W-1:0] wr_ptr;
  logic [P_ADDR_W-1:0] rd_addr;
  logic [P_ADDR_W-1:0] rd_addr_next;
  logic [15:0]         len;
  logic [15:0]         pay_left;
  logic [7:0]          sum;
  logic                discarding;
  cap_state_t          cap_state;
  tx_state_t           tx_state;

  logic capture_en;
  logic can_load;
  logic pay_load;
  logic ck_fire;

  assign capture_en = i_sam_data_vld &&
                      ((cap_state == ST_IDLE && !discarding) || cap_state == ST_CAPT);
  assign can_load   = !o_tx_valid || i_tx_ready;
  assign pay_load   = (tx_state == TX_PAY) && can_load;
  assign ck_fire    = (tx_state == TX_LAST) && o_tx_valid && i_tx_ready;

  // mem_q always tracks mem[rd_addr], so the next payload byte is ready on the cycle it is needed
  always_comb begin
    rd_addr_next = rd_addr;
    if (pay_load) begin
      rd_addr_next = rd_addr + P_ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (capture_en) begin
      mem[wr_ptr] <= i_sam_data;
    end
    mem_q <= mem[rd_addr_next];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cap_state  <= ST_IDLE;
      tx_state   <= TX_IDLE;
      wr_ptr     <= '0;
      rd_addr    <= '0;
      len        <= '0;
      pay_left   <= '0;
      sum        <= '0;
      discarding <= 1'b0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_drop     <= 1'b0;
      o_trunc    <= 1'b0;
    end else begin
      o_drop  <= 1'b0;
      o_trunc <= 1'b0;

      case (cap_state)
        ST_IDLE, ST_CAPT: begin
          if (capture_en) begin
            wr_ptr <= wr_ptr + P_ADDR_W'(1);
            len    <= len + 16'd1;
            sum    <= sum + i_sam_data;
            o_busy <= 1'b1;
            if (i_sam_data_last) begin
              cap_state <= ST_SEND;
              tx_state  <= TX_H0;
              rd_addr   <= '0;
            end else if (len == MAX_LEN_M1) begin
              o_trunc   <= 1'b1;
              cap_state <= ST_SKIP;
            end else begin
              cap_state <= ST_CAPT;
            end
          end else if (i_sam_data_vld) begin
            // tail of a burst that was already being dropped when the last frame finished
            discarding <= !i_sam_data_last;
          end
        end

        ST_SKIP: begin
          if (i_sam_data_vld && i_sam_data_last) begin
            cap_state <= ST_SEND;
            tx_state  <= TX_H0;
            rd_addr   <= '0;
          end
        end

        ST_SEND: begin
          if (i_sam_data_vld) begin
            if (!discarding) begin
              o_drop <= 1'b1;
            end
            discarding <= !i_sam_data_last;
          end
          if (ck_fire) begin
            cap_state <= ST_IDLE;
            wr_ptr    <= '0;
            len       <= '0;
            sum       <= '0;
            o_busy    <= 1'b0;
          end
        end

        default: cap_state <= ST_IDLE;
      endcase

      // tx_state names the byte to load next; TX_LAST waits for the checksum to be taken
      case (tx_state)
        TX_H0: begin
          if (can_load) begin
            o_tx_data  <= P_HDR0;
            o_tx_valid <= 1'b1;
            tx_state   <= TX_H1;
          end
        end

        TX_H1: begin
          if (can_load) begin
            o_tx_data  <= P_HDR1;
            o_tx_valid <= 1'b1;
            tx_state   <= TX_LH;
          end
        end

        TX_LH: begin
          if (can_load) begin
            o_tx_data  <= len[15:8];
            o_tx_valid <= 1'b1;
            tx_state   <= TX_LL;
          end
        end

        TX_LL: begin
          if (can_load) begin
            o_tx_data  <= len[7:0];
            o_tx_valid <= 1'b1;
            pay_left   <= len;
            tx_state   <= TX_PAY;
          end
        end

        TX_PAY: begin
          if (can_load) begin
            o_tx_data  <= mem_q;
            o_tx_valid <= 1'b1;
            rd_addr    <= rd_addr_next;
            pay_left   <= pay_left - 16'd1;
            if (pay_left == 16'd1) begin
              tx_state <= TX_CK;
            end
          end
        end

        TX_CK: begin
          if (can_load) begin
            o_tx_data  <= sum;
            o_tx_valid <= 1'b1;
            tx_state   <= TX_LAST;
          end
        end

        TX_LAST: begin
          if (ck_fire) begin
            o_tx_valid <= 1'b0;
            tx_state   <= TX_IDLE;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_frame_packer.sv
// Directed bench for sample_frame_packer: frames are collected by a negedge monitor
// and compared byte by byte against hand-built expected streams.
module tb_sample_frame_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sam_data;
  logic       sam_vld;
  logic       sam_last;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       drop;
  logic       trunc;

  int total = 0;
  int bad   = 0;

  logic [7:0] burst_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  int         valid_cycles;
  int         drop_cnt;
  int         trunc_cnt;
  int         stall_errs;
  int         ready_mode;
  bit         stall_pend;
  logic [7:0] stall_data;

  always #5 clk = ~clk;

  sample_frame_packer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sam_data     (sam_data),
    .i_sam_data_vld (sam_vld),
    .i_sam_data_last(sam_last),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .o_busy         (busy),
    .o_drop         (drop),
    .o_trunc        (trunc)
  );

  // ready pattern: 0 = held high, 1 = toggling, other = held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = !tx_ready;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // collects accepted bytes and pulse counts, and flags any change while stalled
  initial begin
    stall_pend = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_pend = 1'b0;
      end else begin
        if (tx_valid) valid_cycles++;
        if (drop) drop_cnt++;
        if (trunc) trunc_cnt++;
        if (stall_pend && (!tx_valid || tx_data !== stall_data)) stall_errs++;
        stall_pend = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      end
    end
  end

  task automatic reset_counters();
    @(posedge clk);
    #1;
    rx_q.delete();
    valid_cycles = 0;
    drop_cnt     = 0;
    trunc_cnt    = 0;
    stall_errs   = 0;
  endtask

  task automatic drive_burst();
    for (int i = 0; i < burst_q.size(); i++) begin
      @(posedge clk);
      #1;
      sam_vld  = 1'b1;
      sam_data = burst_q[i];
      sam_last = (i == burst_q.size() - 1);
    end
    @(posedge clk);
    #1;
    sam_vld  = 1'b0;
    sam_last = 1'b0;
    sam_data = 8'h00;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy && !tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    sam_vld    = 1'b0;
    sam_last   = 1'b0;
    sam_data   = 8'h00;
    tx_ready   = 1'b1;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset tx_valid: got %b want 0", tx_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    total++;
    if (drop !== 1'b0 || trunc !== 1'b0) begin
      bad++; $display("[TB] FAIL reset pulses: got drop=%b trunc=%b want 0 0", drop, trunc);
    end
    total++;
    if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset tx_data: got %02h want 00", tx_data); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    ready_mode = 0;
    reset_counters();
    burst_q.delete();
    burst_q.push_back(8'h01); burst_q.push_back(8'h02);
    burst_q.push_back(8'h03); burst_q.push_back(8'h04);
    drive_burst();
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL basic done: got timeout want idle"); end
    exp_q.delete();
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    exp_q.push_back(8'h04); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04); exp_q.push_back(8'h0A);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL basic size: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("[TB] FAIL basic byte %0d: got %02h want %02h", i,
                        (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++;
    if (valid_cycles != 9) begin
      bad++; $display("[TB] FAIL basic valid cycles: got %0d want 9", valid_cycles);
    end
  endtask

  task automatic test_backpressure();
    bit         ok;
    logic [7:0] ck;
    ready_mode = 1;
    reset_counters();
    burst_q.delete();
    ck = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      burst_q.push_back(8'(i));
      ck = ck + 8'(i);
    end
    drive_burst();
    wait_done(5000, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL bp done: got timeout want idle"); end
    exp_q.delete();
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
    exp_q.push_back(8'h03); exp_q.push_back(8'hE8);
    for (int i = 0; i < 1000; i++) exp_q.push_back(8'(i));
    exp_q.push_back(ck);
    total++;
    if (rx_q.size() != 1005) begin
      bad++; $display("[TB] FAIL bp size: got %0d want 1005", rx_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("[TB] FAIL bp byte %0d: got %02h want %02h", i,
                        (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++;
    if (stall_errs != 0) begin
      bad++; $display("[TB] FAIL bp stall stability: got %0d changes want 0", stall_errs);
    end
  endtask

  task automatic test_single();
    bit ok;
    ready_mode = 0;
    reset_counters();
    burst_q.delete();
    burst_q.push_back(8'hFF);
    drive_burst();
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL single done: got timeout want idle"); end
    exp_q.delete();
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL single size: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("[TB] FAIL single byte %0d: got %02h want %02h", i,
                        (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    ready_mode = 2;
    reset_counters();
    burst_q.delete();
    for (int i = 0; i < 5; i++) burst_q.push_back(8'(8'h31 + i));
    drive_burst();
    repeat (3) @(posedge clk);
    burst_q.delete();
    for (int i = 0; i < 10; i++) burst_q.push_back(8'(8'h80 + i));
    drive_burst();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (drop_cnt != 1) begin bad++; $display("[TB] FAIL ovf drop pulses: got %0d want 1", drop_cnt); end
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
      bad++; $display("[TB] FAIL ovf stalled head: got valid=%b data=%02h want 1 55", tx_valid, tx_data);
    end
    ready_mode = 0;
    wait_done(200, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL ovf done: got timeout want idle"); end
    exp_q.delete();
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(8'h00); exp_q.push_back(8'h05);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33);
    exp_q.push_back(8'h34); exp_q.push_back(8'h35); exp_q.push_back(8'hFF);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL ovf frame1 size: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("[TB] FAIL ovf frame1 byte %0d: got %02h want %02h", i,
                        (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    reset_counters();
    burst_q.delete();
    burst_q.push_back(8'h21); burst_q.push_back(8'h22); burst_q.push_back(8'h23);
    drive_burst();
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL ovf frame3 done: got timeout want idle"); end
    exp_q.delete();
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(8'h00); exp_q.push_back(8'h03);
    exp_q.push_back(8'h21); exp_q.push_back(8'h22); exp_q.push_back(8'h23); exp_q.push_back(8'h66);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL ovf frame3 size: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("[TB] FAIL ovf frame3 byte %0d: got %02h want %02h", i,
                        (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++;
    if (drop_cnt != 0) begin bad++; $display("[TB] FAIL ovf frame3 drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_trunc();
    bit ok;
    ready_mode = 0;
    reset_counters();
    burst_q.delete();
    for (int i = 0; i < 1030; i++) burst_q.push_back(8'h11);
    drive_burst();
    wait_done(3000, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL trunc done: got timeout want idle"); end
    total++;
    if (trunc_cnt != 1) begin bad++; $display("[TB] FAIL trunc pulses: got %0d want 1", trunc_cnt); end
    exp_q.delete();
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
    exp_q.push_back(8'h04); exp_q.push_back(8'h00);
    for (int i = 0; i < 1024; i++) exp_q.push_back(8'h11);
    exp_q.push_back(8'h00);
    total++;
    if (rx_q.size() != 1029) begin
      bad++; $display("[TB] FAIL trunc size: got %0d want 1029", rx_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("[TB] FAIL trunc byte %0d: got %02h want %02h", i,
                        (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ready_mode = 0;
    reset_counters();
    burst_q.delete();
    for (int i = 0; i < 1000; i++) burst_q.push_back(8'(i));
    drive_burst();
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rx_q.size() >= 103) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL rstmid reach byte 100: got %0d bytes want 103", rx_q.size()); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid tx_valid: got %b want 0", tx_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid no resume: got valid=%b want 0", tx_valid); end
    reset_counters();
    burst_q.delete();
    burst_q.push_back(8'h07); burst_q.push_back(8'h08); burst_q.push_back(8'h09);
    drive_burst();
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL rstmid done: got timeout want idle"); end
    exp_q.delete();
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(8'h00); exp_q.push_back(8'h03);
    exp_q.push_back(8'h07); exp_q.push_back(8'h08); exp_q.push_back(8'h09); exp_q.push_back(8'h18);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL rstmid size: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("[TB] FAIL rstmid byte %0d: got %02h want %02h", i,
                        (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_overflow();
    test_trunc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
